axi_lite_cmd_arbiter: RTL and testbench
=======================================

AXI_LITE_CMD_ARBITER -- requirements
Module: axi_lite_cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WDOG_CYCLES, default 1024, wait-for-done cycles before the watchdog flag sets.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock; all state in this domain.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester transaction request, held until accepted.
REQ-006 SHALL have port req_write  input  NUM_REQ  per-requester direction: 1 write, 0 read.
REQ-007 SHALL have port req_addr  input  NUM_REQ*32  per-requester address; slice i = bits [32i+31:32i].
REQ-008 SHALL have port req_wdata  input  NUM_REQ*32  per-requester write data, same slicing.
REQ-009 SHALL have port req_ack  output  NUM_REQ  one-hot, one-cycle pulse: request accepted.
REQ-010 SHALL have port rsp_valid  output  NUM_REQ  one-hot, one-cycle pulse: transaction complete.
REQ-011 SHALL have port rsp_rdata  output  32  read data, valid with rsp_valid.
REQ-012 SHALL have port m_start  output  1  start pulse to the AXI4-Lite master.
REQ-013 SHALL have port m_write_en  output  1  direction to master.
REQ-014 SHALL have port m_addr  output  32  address to master.
REQ-015 SHALL have port m_wdata  output  32  write data to master.
REQ-016 SHALL have port m_rdata  input  32  read data from master, valid in the m_done cycle.
REQ-017 SHALL have port m_done  input  1  one-cycle completion pulse from master.
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-019 SHALL have port wdog_flag  output  1  sticky: a transaction exceeded WDOG_CYCLES.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: if any req_valid, SHALL grant one requester by round-robin, latch its write/addr/wdata and owner index, pulse req_ack[owner], go to ISSUE next cycle.
REQ-022 Round-robin SHALL search from (last_owner+1) mod NUM_REQ upward with wrap; last_owner resets to NUM_REQ-1 so requester 0 wins first.
REQ-023 ISSUE: SHALL assert m_start for exactly one cycle with m_write_en/m_addr/m_wdata from latched values; go to WAIT.
REQ-024 m_write_en, m_addr, m_wdata SHALL hold latched values from ISSUE until leaving WAIT; SHALL be 0 in IDLE.
REQ-025 WAIT: on m_done SHALL capture m_rdata (reads) or 0 (writes) into rsp_rdata register and go to RESP.
REQ-026 RESP: SHALL pulse rsp_valid[owner] for one cycle with rsp_rdata stable, update last_owner, return to IDLE.
REQ-027 Minimum accept-to-response latency SHALL be: req_ack in cycle T, m_start T+1, rsp_valid one cycle after the m_done cycle; earliest next req_ack is the cycle after RESP.
REQ-028 m_done outside WAIT SHALL be ignored; req_valid changes outside IDLE SHALL be ignored.
REQ-029 A requester deasserting req_valid before ack SHALL simply lose arbitration; no state is kept for it.
REQ-030 Watchdog counter SHALL clear on entry to WAIT, increment each WAIT cycle, saturate at WDOG_CYCLES; reaching WDOG_CYCLES SHALL set wdog_flag, which only reset clears; the transaction is not aborted.
REQ-031 rsp_rdata SHALL hold its last value between responses.

Reset
REQ-032 Asserting rst_n low SHALL immediately force state IDLE and all outputs 0 (req_ack, rsp_valid, rsp_rdata, m_start, m_write_en, m_addr, m_wdata, busy, wdog_flag), last_owner NUM_REQ-1, watchdog 0.
REQ-033 Reset mid-transaction SHALL drop the in-flight transaction with no rsp_valid; first grant after release follows REQ-022.

Verification
REQ-034 Single read: req_valid[2]=1, addr 0x1000; m_done after 3 cycles with m_rdata 0xDEADBEEF -> req_ack=4'b0100, one m_start with addr 0x1000, write_en 0, rsp_valid=4'b0100 with rsp_rdata 0xDEADBEEF.
REQ-035 Fairness: all four req_valid held high, writes, m_done 2 cycles after each m_start -> grant order 0,1,2,3,0; each exactly one m_start.
REQ-036 Write: req_valid[1]=1, write, addr 0x20, wdata 0x5A5A5A5A -> m_write_en=1, m_wdata 0x5A5A5A5A held through WAIT, rsp_rdata 0.
REQ-037 Stray m_done in IDLE and new req_valid during WAIT -> no rsp_valid, no extra m_start; waiting request granted after RESP.
REQ-038 Watchdog: WDOG_CYCLES=8, m_done withheld 10 cycles -> wdog_flag rises after 8 WAIT cycles, stays high; rsp_valid still issued on m_done.
REQ-039 rst_n low during WAIT -> all outputs 0 immediately; after release, requester 0 granted first; no response for dropped transaction.

Source files
------------

// File: rtl/axi_lite_cmd_arbiter_if.sv
// Bus bundle shared by the requesters, the command arbiter and the
// downstream AXI4-Lite master engine. The arbiter uses the slave view.
// The environment (requesters plus master engine) uses the master view.
interface axi_lite_cmd_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_write;
   logic [NUM_REQ*32-1:0] req_addr;
   logic [NUM_REQ*32-1:0] req_wdata;
   logic [NUM_REQ-1:0]    req_ack;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [31:0]           rsp_rdata;
   logic                  m_start;
   logic                  m_write_en;
   logic [31:0]           m_addr;
   logic [31:0]           m_wdata;
   logic [31:0]           m_rdata;
   logic                  m_done;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, m_rdata, m_done,
      output req_ack, rsp_valid, rsp_rdata, m_start, m_write_en, m_addr, m_wdata
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, m_rdata, m_done,
      input  req_ack, rsp_valid, rsp_rdata, m_start, m_write_en, m_addr, m_wdata
   );
endinterface

// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin command arbiter in front of a single AXI4-Lite master engine.
// Exactly one transaction is in flight at a time. The flow is
// IDLE -> ISSUE -> WAIT -> RESP.
// A sticky watchdog flag records any wait for completion that lasts too long.
// The watchdog does not abort the transaction.
module axi_lite_cmd_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   axi_lite_cmd_arbiter_if.slave bus,
   output logic                  busy,
   output logic                  wdog_flag
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] WDOG_MAX   = CNT_W'(WDOG_CYCLES);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t             state;
   state_t             state_next;
   logic [IDX_W-1:0]   last_owner;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_found;
   logic               lat_write;
   logic [31:0]        lat_addr;
   logic [31:0]        lat_wdata;
   logic [31:0]        rsp_rdata_q;
   logic [CNT_W-1:0]   wdog_cnt;
   logic               wdog_flag_q;
   logic [NUM_REQ-1:0] ack_d;
   logic [NUM_REQ-1:0] rsp_d;
   logic               start_d;
   logic               drive_bus;

   // Pick the first valid requester after the previous owner, wrapping around
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_owner) + k) % NUM_REQ;
         if (!grant_found && bus.req_valid[idx]) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'(idx);
         end
      end
   end

   // Transaction state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode plus the one-cycle ack/start/response pulses.
   // The ack is gated by rst_n so that it stays low while reset is held.
   always_comb begin
      state_next = state;
      ack_d      = '0;
      rsp_d      = '0;
      start_d    = 1'b0;
      drive_bus  = 1'b0;
      case (state)
         IDLE: begin
            if (grant_found && rst_n) begin
               ack_d[grant_idx] = 1'b1;
               state_next       = ISSUE;
            end
         end
         ISSUE: begin
            start_d    = 1'b1;
            drive_bus  = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            drive_bus = 1'b1;
            if (bus.m_done) begin
               state_next = RESP;
            end
         end
         RESP: begin
            rsp_d[owner] = 1'b1;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Latch the granted command, capture read data, track owner and watchdog
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_write   <= 1'b0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
         owner       <= '0;
         last_owner  <= LAST_RESET;
         rsp_rdata_q <= '0;
         wdog_cnt    <= '0;
         wdog_flag_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  lat_write <= bus.req_write[grant_idx];
                  lat_addr  <= bus.req_addr[32*int'(grant_idx) +: 32];
                  lat_wdata <= bus.req_wdata[32*int'(grant_idx) +: 32];
                  owner     <= grant_idx;
               end
            end
            ISSUE: begin
               wdog_cnt <= '0;
            end
            WAIT: begin
               if (wdog_cnt != WDOG_MAX) begin
                  wdog_cnt <= wdog_cnt + CNT_W'(1);
               end
               if (wdog_cnt == WDOG_MAX - CNT_W'(1)) begin
                  wdog_flag_q <= 1'b1;
               end
               if (bus.m_done) begin
                  rsp_rdata_q <= lat_write ? 32'h0 : bus.m_rdata;
               end
            end
            RESP: begin
               last_owner <= owner;
            end
            default: ;
         endcase
      end
   end

   // Drive the master only from ISSUE through WAIT; the bus is zero elsewhere
   always_comb begin
      bus.req_ack    = ack_d;
      bus.rsp_valid  = rsp_d;
      bus.rsp_rdata  = rsp_rdata_q;
      bus.m_start    = start_d;
      bus.m_write_en = drive_bus & lat_write;
      bus.m_addr     = drive_bus ? lat_addr : 32'h0;
      bus.m_wdata    = drive_bus ? lat_wdata : 32'h0;
      busy           = (state != IDLE);
      wdog_flag      = wdog_flag_q;
   end
endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Self-checking bench for axi_lite_cmd_arbiter. It combines directed scenarios
// with a randomized run that is checked against a transaction-level model.
module tb_axi_lite_cmd_arbiter;
   localparam int NR = 4;
   localparam int WD = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   logic wdog_flag;
   int   total = 0;
   int   bad   = 0;

   axi_lite_cmd_arbiter_if #(.NUM_REQ(NR)) bus();

   axi_lite_cmd_arbiter #(.NUM_REQ(NR), .WDOG_CYCLES(WD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .busy      (busy),
      .wdog_flag (wdog_flag)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Global time limit so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.m_rdata   = '0;
      bus.m_done    = 1'b0;
   endtask

   task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
      bus.req_valid[i]          = 1'b1;
      bus.req_write[i]          = wr;
      bus.req_addr[i*32 +: 32]  = a;
      bus.req_wdata[i*32 +: 32] = d;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      clear_inputs();
      #2;
      rst_n = 1'b0;
      tick();
      bus.req_valid = '1;
      #1;
      total++;
      if (bus.req_ack !== 4'b0 || bus.rsp_valid !== 4'b0 || bus.m_start !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_ctrl: got ack=%b rsp=%b start=%b busy=%b expected all 0",
                  bus.req_ack, bus.rsp_valid, bus.m_start, busy);
      end
      total++;
      if (bus.rsp_rdata !== 32'h0 || bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0 ||
          bus.m_write_en !== 1'b0 || wdog_flag !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_data: got rdata=%h addr=%h wdata=%h we=%b wdog=%b expected all 0",
                  bus.rsp_rdata, bus.m_addr, bus.m_wdata, bus.m_write_en, wdog_flag);
      end
      bus.req_valid = '0;
      tick();
      rst_n = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0 || bus.req_ack !== 4'b0) begin
         bad++;
         $display("[TB] FAIL reset_release_idle: got busy=%b ack=%b expected 0/0", busy, bus.req_ack);
      end
   endtask

   task automatic test_single_read();
      int starts;
      int early;
      starts = 0;
      early  = 0;
      apply_reset();
      set_req(2, 1'b0, 32'h1000, 32'h0);
      #1;
      total++;
      if (bus.req_ack !== 4'b0100) begin
         bad++;
         $display("[TB] FAIL read_ack: got %b expected 0100", bus.req_ack);
      end
      tick();
      bus.req_valid = '0;
      #1;
      total++;
      if (bus.m_start !== 1'b1 || bus.m_addr !== 32'h1000 || bus.m_write_en !== 1'b0) begin
         bad++;
         $display("[TB] FAIL read_issue: got start=%b addr=%h we=%b expected 1/00001000/0",
                  bus.m_start, bus.m_addr, bus.m_write_en);
      end
      if (bus.m_start === 1'b1) starts++;
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (c == 3) begin
            bus.m_done  = 1'b1;
            bus.m_rdata = 32'hDEADBEEF;
         end
         #1;
         if (bus.m_start === 1'b1) starts++;
         if (bus.rsp_valid !== 4'b0) early++;
      end
      tick();
      bus.m_done  = 1'b0;
      bus.m_rdata = 32'h0;
      #1;
      total++;
      if (bus.rsp_valid !== 4'b0100 || bus.rsp_rdata !== 32'hDEADBEEF) begin
         bad++;
         $display("[TB] FAIL read_rsp: got rsp=%b rdata=%h expected 0100/deadbeef",
                  bus.rsp_valid, bus.rsp_rdata);
      end
      total++;
      if (starts != 1 || early != 0) begin
         bad++;
         $display("[TB] FAIL read_pulses: got starts=%0d early_rsp=%0d expected 1/0", starts, early);
      end
      tick();
      #1;
      total++;
      if (bus.rsp_valid !== 4'b0 || bus.rsp_rdata !== 32'hDEADBEEF || busy !== 1'b0 || bus.m_addr !== 32'h0) begin
         bad++;
         $display("[TB] FAIL read_hold: got rsp=%b rdata=%h busy=%b addr=%h expected 0/deadbeef/0/0",
                  bus.rsp_valid, bus.rsp_rdata, busy, bus.m_addr);
      end
   endtask

   task automatic test_write();
      int hold_err;
      hold_err = 0;
      set_req(1, 1'b1, 32'h20, 32'h5A5A5A5A);
      #1;
      total++;
      if (bus.req_ack !== 4'b0010) begin
         bad++;
         $display("[TB] FAIL write_ack: got %b expected 0010", bus.req_ack);
      end
      tick();
      bus.req_valid = '0;
      #1;
      total++;
      if (bus.m_start !== 1'b1 || bus.m_write_en !== 1'b1 || bus.m_wdata !== 32'h5A5A5A5A || bus.m_addr !== 32'h20) begin
         bad++;
         $display("[TB] FAIL write_issue: got start=%b we=%b wdata=%h addr=%h expected 1/1/5a5a5a5a/00000020",
                  bus.m_start, bus.m_write_en, bus.m_wdata, bus.m_addr);
      end
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 4) begin
            bus.m_done  = 1'b1;
            bus.m_rdata = 32'h12345678;
         end
         #1;
         if (bus.m_write_en !== 1'b1 || bus.m_wdata !== 32'h5A5A5A5A || bus.m_addr !== 32'h20) hold_err++;
      end
      total++;
      if (hold_err != 0) begin
         bad++;
         $display("[TB] FAIL write_hold_wait: got %0d bad WAIT cycles expected 0", hold_err);
      end
      tick();
      bus.m_done  = 1'b0;
      bus.m_rdata = 32'h0;
      #1;
      total++;
      if (bus.rsp_valid !== 4'b0010 || bus.rsp_rdata !== 32'h0) begin
         bad++;
         $display("[TB] FAIL write_rsp: got rsp=%b rdata=%h expected 0010/00000000", bus.rsp_valid, bus.rsp_rdata);
      end
      tick();
      #1;
      total++;
      if (bus.m_write_en !== 1'b0 || bus.m_wdata !== 32'h0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL write_idle_bus: got we=%b wdata=%h busy=%b expected 0/0/0",
                  bus.m_write_en, bus.m_wdata, busy);
      end
   endtask

   task automatic test_fairness();
      int order[$];
      int starts;
      int rsps;
      int due;
      int bad_order;
      starts    = 0;
      rsps      = 0;
      due       = -1;
      bad_order = 0;
      apply_reset();
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 32'h100 * i, 32'hA000 + i);
      for (int c = 0; c < 200 && rsps < 5; c++) begin
         bus.m_done = (c == due);
         #1;
         for (int i = 0; i < NR; i++) if (bus.req_ack[i] === 1'b1) order.push_back(i);
         if (bus.m_start === 1'b1) begin
            starts++;
            due = c + 2;
         end
         if (bus.rsp_valid !== 4'b0) begin
            rsps++;
            if (rsps == 5) bus.req_valid = '0;
         end
         tick();
      end
      bus.m_done = 1'b0;
      total++;
      if (order.size() != 5) begin
         bad++;
         $display("[TB] FAIL fair_grant_count: got %0d expected 5", order.size());
      end else begin
         for (int k = 0; k < 5; k++) if (order[k] != k % NR) bad_order++;
         total++;
         if (bad_order != 0) begin
            bad++;
            $display("[TB] FAIL fair_order: got %0d %0d %0d %0d %0d expected 0 1 2 3 0",
                     order[0], order[1], order[2], order[3], order[4]);
         end
      end
      total++;
      if (starts != 5) begin
         bad++;
         $display("[TB] FAIL fair_starts: got %0d expected 5", starts);
      end
   endtask

   task automatic test_stray();
      int stray_err;
      stray_err = 0;
      bus.m_done = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         if (busy !== 1'b0 || bus.rsp_valid !== 4'b0 || bus.m_start !== 1'b0) stray_err++;
      end
      bus.m_done = 1'b0;
      total++;
      if (stray_err != 0) begin
         bad++;
         $display("[TB] FAIL stray_idle_done: got %0d reacting cycles expected 0", stray_err);
      end
      set_req(3, 1'b0, 32'h300, 32'h0);
      #1;
      total++;
      if (bus.req_ack !== 4'b1000) begin
         bad++;
         $display("[TB] FAIL stray_ack3: got %b expected 1000", bus.req_ack);
      end
      tick();
      bus.req_valid = '0;
      bus.m_done    = 1'b1;
      #1;
      total++;
      if (bus.m_start !== 1'b1) begin
         bad++;
         $display("[TB] FAIL stray_issue: got start=%b expected 1", bus.m_start);
      end
      tick();
      bus.m_done = 1'b0;
      set_req(1, 1'b1, 32'h44, 32'hABCD0001);
      #1;
      total++;
      if (bus.req_ack !== 4'b0 || bus.m_start !== 1'b0 || bus.rsp_valid !== 4'b0) begin
         bad++;
         $display("[TB] FAIL stray_wait_quiet: got ack=%b start=%b rsp=%b expected 0/0/0",
                  bus.req_ack, bus.m_start, bus.rsp_valid);
      end
      tick();
      bus.m_done  = 1'b1;
      bus.m_rdata = 32'hCAFE0003;
      #1;
      tick();
      bus.m_done  = 1'b0;
      bus.m_rdata = 32'h0;
      #1;
      total++;
      if (bus.rsp_valid !== 4'b1000 || bus.rsp_rdata !== 32'hCAFE0003 || bus.req_ack !== 4'b0) begin
         bad++;
         $display("[TB] FAIL stray_rsp3: got rsp=%b rdata=%h ack=%b expected 1000/cafe0003/0000",
                  bus.rsp_valid, bus.rsp_rdata, bus.req_ack);
      end
      tick();
      total++;
      if (bus.req_ack !== 4'b0010) begin
         bad++;
         $display("[TB] FAIL stray_waiting_grant: got %b expected 0010", bus.req_ack);
      end
      tick();
      bus.req_valid = '0;
      #1;
      total++;
      if (bus.m_start !== 1'b1 || bus.m_write_en !== 1'b1 || bus.m_addr !== 32'h44 || bus.m_wdata !== 32'hABCD0001) begin
         bad++;
         $display("[TB] FAIL stray_issue1: got start=%b we=%b addr=%h wdata=%h expected 1/1/00000044/abcd0001",
                  bus.m_start, bus.m_write_en, bus.m_addr, bus.m_wdata);
      end
      tick();
      bus.m_done = 1'b1;
      tick();
      bus.m_done = 1'b0;
      #1;
      total++;
      if (bus.rsp_valid !== 4'b0010 || bus.rsp_rdata !== 32'h0) begin
         bad++;
         $display("[TB] FAIL stray_rsp1: got rsp=%b rdata=%h expected 0010/00000000", bus.rsp_valid, bus.rsp_rdata);
      end
      tick();
   endtask

   task automatic test_random();
      logic [NR-1:0] pend;
      logic [NR-1:0] pw;
      logic [31:0]   pa[NR];
      logic [31:0]   pd[NR];
      logic [NR-1:0] exp_ack;
      logic [NR-1:0] exp_rsp;
      logic [31:0]   exp_rd;
      logic [31:0]   exp_addr;
      logic [31:0]   exp_wd;
      logic [31:0]   cap;
      logic [31:0]   oa;
      logic [31:0]   od;
      logic          ow;
      logic          exp_start;
      logic          exp_busy;
      logic          exp_we;
      bit            inflight;
      bit            found;
      int            model_last;
      int            t_ack;
      int            t_done;
      int            own;
      int            w;
      int            idx;
      int            nrsp;
      pend = '0; pw = '0; exp_rd = '0; cap = '0; oa = '0; od = '0; ow = 1'b0;
      inflight = 0; model_last = NR - 1; t_ack = 0; t_done = 0; own = 0; w = 0; nrsp = 0;
      for (int i = 0; i < NR; i++) begin
         pa[i] = '0;
         pd[i] = '0;
      end
      apply_reset();
      for (int cyc = 0; cyc < 3000 && nrsp < 30; cyc++) begin
         tick();
         if (inflight && cyc == t_done + 2) inflight = 0;
         for (int i = 0; i < NR; i++) begin
            if (!pend[i]) begin
               if ($urandom_range(0, 99) < 30) begin
                  pend[i] = 1'b1;
                  pw[i]   = 1'($urandom_range(0, 1));
                  pa[i]   = $urandom;
                  pd[i]   = $urandom;
               end
            end else if ($urandom_range(0, 99) < 5) begin
               pend[i] = 1'b0;
            end
            bus.req_addr[i*32 +: 32]  = pa[i];
            bus.req_wdata[i*32 +: 32] = pd[i];
         end
         bus.req_valid = pend;
         bus.req_write = pw;
         bus.m_rdata   = $urandom;
         if (inflight && cyc == t_done) bus.m_done = 1'b1;
         else if (inflight && cyc >= t_ack + 2 && cyc < t_done) bus.m_done = 1'b0;
         else bus.m_done = ($urandom_range(0, 9) == 0);
         #1;
         if (inflight && cyc == t_done) cap = ow ? 32'h0 : bus.m_rdata;
         exp_ack = '0;
         found   = 0;
         if (!inflight) begin
            for (int k = 1; k <= NR; k++) begin
               idx = (model_last + k) % NR;
               if (!found && pend[idx]) begin
                  found = 1;
                  w     = idx;
               end
            end
            if (found) exp_ack[w] = 1'b1;
         end
         exp_start = inflight && cyc == t_ack + 1;
         exp_busy  = inflight && cyc >= t_ack + 1 && cyc <= t_done + 1;
         exp_we    = (inflight && cyc >= t_ack + 1 && cyc <= t_done) ? ow : 1'b0;
         exp_addr  = (inflight && cyc >= t_ack + 1 && cyc <= t_done) ? oa : 32'h0;
         exp_wd    = (inflight && cyc >= t_ack + 1 && cyc <= t_done) ? od : 32'h0;
         exp_rsp   = '0;
         if (inflight && cyc == t_done + 1) begin
            exp_rsp[own] = 1'b1;
            exp_rd       = cap;
         end
         total++;
         if (bus.req_ack !== exp_ack) begin
            bad++;
            $display("[TB] FAIL rnd_ack cyc %0d: got %b expected %b", cyc, bus.req_ack, exp_ack);
         end
         total++;
         if (bus.m_start !== exp_start || busy !== exp_busy) begin
            bad++;
            $display("[TB] FAIL rnd_start_busy cyc %0d: got %b/%b expected %b/%b",
                     cyc, bus.m_start, busy, exp_start, exp_busy);
         end
         total++;
         if (bus.m_write_en !== exp_we || bus.m_addr !== exp_addr || bus.m_wdata !== exp_wd) begin
            bad++;
            $display("[TB] FAIL rnd_bus cyc %0d: got %b/%h/%h expected %b/%h/%h",
                     cyc, bus.m_write_en, bus.m_addr, bus.m_wdata, exp_we, exp_addr, exp_wd);
         end
         total++;
         if (bus.rsp_valid !== exp_rsp || bus.rsp_rdata !== exp_rd || wdog_flag !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rnd_rsp cyc %0d: got %b/%h/%b expected %b/%h/0",
                     cyc, bus.rsp_valid, bus.rsp_rdata, wdog_flag, exp_rsp, exp_rd);
         end
         if (exp_rsp != '0) begin
            model_last = own;
            nrsp++;
         end
         if (exp_ack != '0) begin
            inflight = 1;
            t_ack    = cyc;
            t_done   = cyc + 2 + int'($urandom_range(0, 3));
            own      = w;
            ow       = pw[w];
            oa       = pa[w];
            od       = pd[w];
            pend[w]  = 1'b0;
         end
      end
      clear_inputs();
      total++;
      if (nrsp < 30) begin
         bad++;
         $display("[TB] FAIL rnd_timeout: got %0d responses expected 30", nrsp);
      end
      repeat (8) tick();
   endtask

   task automatic test_watchdog();
      apply_reset();
      set_req(0, 1'b0, 32'h80, 32'h0);
      #1;
      total++;
      if (bus.req_ack !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL wdog_ack: got %b expected 0001", bus.req_ack);
      end
      tick();
      bus.req_valid = '0;
      for (int w = 1; w <= 11; w++) begin
         tick();
         if (w == 11) begin
            bus.m_done  = 1'b1;
            bus.m_rdata = 32'h0BADF00D;
         end
         #1;
         if (w == 8) begin
            total++;
            if (wdog_flag !== 1'b0) begin
               bad++;
               $display("[TB] FAIL wdog_early: got %b expected 0 after 7 WAIT cycles", wdog_flag);
            end
         end
         if (w == 9) begin
            total++;
            if (wdog_flag !== 1'b1) begin
               bad++;
               $display("[TB] FAIL wdog_rise: got %b expected 1 after 8 WAIT cycles", wdog_flag);
            end
         end
         if (w == 10) begin
            total++;
            if (busy !== 1'b1 || bus.m_addr !== 32'h80) begin
               bad++;
               $display("[TB] FAIL wdog_no_abort: got busy=%b addr=%h expected 1/00000080", busy, bus.m_addr);
            end
         end
      end
      tick();
      bus.m_done  = 1'b0;
      bus.m_rdata = 32'h0;
      #1;
      total++;
      if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata !== 32'h0BADF00D || wdog_flag !== 1'b1) begin
         bad++;
         $display("[TB] FAIL wdog_rsp: got rsp=%b rdata=%h flag=%b expected 0001/0badf00d/1",
                  bus.rsp_valid, bus.rsp_rdata, wdog_flag);
      end
      tick();
      tick();
      total++;
      if (wdog_flag !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL wdog_sticky: got flag=%b busy=%b expected 1/0", wdog_flag, busy);
      end
   endtask

   task automatic test_reset_mid();
      int seen2;
      seen2 = 0;
      set_req(2, 1'b1, 32'h2000, 32'h77);
      #1;
      total++;
      if (bus.req_ack !== 4'b0100) begin
         bad++;
         $display("[TB] FAIL rmid_ack: got %b expected 0100", bus.req_ack);
      end
      tick();
      bus.req_valid = '0;
      tick();
      total++;
      if (busy !== 1'b1 || bus.m_write_en !== 1'b1) begin
         bad++;
         $display("[TB] FAIL rmid_in_wait: got busy=%b we=%b expected 1/1", busy, bus.m_write_en);
      end
      rst_n = 1'b0;
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h4000 + i, 32'h0);
      #1;
      total++;
      if (bus.req_ack !== 4'b0 || bus.rsp_valid !== 4'b0 || bus.m_start !== 1'b0 || busy !== 1'b0 ||
          bus.m_write_en !== 1'b0 || bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0 ||
          bus.rsp_rdata !== 32'h0 || wdog_flag !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rmid_outputs: got ack=%b rsp=%b start=%b busy=%b we=%b addr=%h wdata=%h rdata=%h flag=%b expected all 0",
                  bus.req_ack, bus.rsp_valid, bus.m_start, busy, bus.m_write_en, bus.m_addr,
                  bus.m_wdata, bus.rsp_rdata, wdog_flag);
      end
      tick();
      bus.m_done = 1'b1;
      tick();
      bus.m_done = 1'b0;
      rst_n      = 1'b1;
      #1;
      total++;
      if (bus.req_ack !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL rmid_first_grant: got %b expected 0001", bus.req_ack);
      end
      tick();
      bus.req_valid = '0;
      #1;
      if (bus.rsp_valid[2] === 1'b1) seen2++;
      tick();
      if (bus.rsp_valid[2] === 1'b1) seen2++;
      bus.m_done  = 1'b1;
      bus.m_rdata = 32'h600D0000;
      tick();
      bus.m_done  = 1'b0;
      #1;
      total++;
      if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata !== 32'h600D0000) begin
         bad++;
         $display("[TB] FAIL rmid_rsp0: got rsp=%b rdata=%h expected 0001/600d0000", bus.rsp_valid, bus.rsp_rdata);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus.rsp_valid[2] === 1'b1) seen2++;
      end
      total++;
      if (seen2 != 0) begin
         bad++;
         $display("[TB] FAIL rmid_dropped_rsp: got %0d responses for requester 2 expected 0", seen2);
      end
   endtask

   // Scenario sequence
   initial begin
      clear_inputs();
      test_reset();
      test_single_read();
      test_write();
      test_fairness();
      test_stray();
      test_random();
      test_watchdog();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
